// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control-word layout and the per-lane
// decode record shared by the decode stage and its lane decoder.
package decode_pkg;

  localparam int CTRL_W = 11;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int C_AOP    = 0;
  localparam int C_BW     = 2;
  localparam int C_MWR    = 3;
  localparam int C_MRE    = 4;
  localparam int C_M2R    = 5;
  localparam int C_ALUSRC = 6;
  localparam int C_RW     = 7;
  localparam int C_BR     = 8;
  localparam int C_JMP    = 9;
  localparam int C_PCA    = 10;

  // aluop: 00 address add, 01 compare, 10 funct3-decoded
  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_BR  = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  typedef struct packed {
    logic              illegal;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrls;
    logic [3:0]        alu_sel;
  } lane_dec_t;

  function automatic logic [3:0] alu_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and issue-side bundle handshakes
// of the decode stage.
interface fetch_if #(
  parameter int N_LANES = 2,
  parameter int XLEN    = 32
);
  logic                   valid;
  logic                   ready;
  logic [XLEN-1:0]        pc;
  logic [N_LANES*32-1:0]  instr;
  logic [N_LANES-1:0]     mask;

  modport master (output valid, pc, instr, mask, input ready);
  modport slave  (input valid, pc, instr, mask, output ready);
endinterface

interface issue_if
  import decode_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int XLEN    = 32
);
  logic                       valid;
  logic                       ready;
  logic [N_LANES*XLEN-1:0]    pc;
  logic [N_LANES-1:0]         lane_vld;
  logic [N_LANES-1:0]         illegal;
  logic [N_LANES*5-1:0]       rd;
  logic [N_LANES*5-1:0]       rs1;
  logic [N_LANES*5-1:0]       rs2;
  logic [N_LANES*XLEN-1:0]    imm;
  logic [N_LANES*CTRL_W-1:0]  ctrls;
  logic [N_LANES*4-1:0]       alu_sel;

  modport master (
    output valid, pc, lane_vld, illegal, rd, rs1, rs2,
    output imm, ctrls, alu_sel,
    input  ready
  );
  modport slave (
    input  valid, pc, lane_vld, illegal, rd, rs1, rs2,
    input  imm, ctrls, alu_sel,
    output ready
  );
endinterface

// File: rtl/decode_lane.sv
// decode_lane: combinational RV32I decoder for one lane; fields
// a format does not use are left zero.
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output lane_dec_t   dec_o
);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [CTRL_W-1:0] c;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign rd  = instr_i[11:7];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    dec_o = '0;
    c     = '0;
    unique case (1'b1)
      (opc == OP_R): begin
        c[C_RW]         = 1'b1;
        c[C_AOP +: 2]   = AOP_FN;
        dec_o.rd        = rd;
        dec_o.rs1       = rs1;
        dec_o.rs2       = rs2;
        dec_o.alu_sel   = alu_f3(f3, instr_i[30]);
      end
      (opc == OP_IMM): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        c[C_AOP +: 2]   = AOP_FN;
        dec_o.rd        = rd;
        dec_o.rs1       = rs1;
        dec_o.imm       = imm_i;
        // bit 30 of an I-immediate only selects SRAI
        dec_o.alu_sel   = alu_f3(f3,
                            instr_i[30] & (f3 == 3'b101));
      end
      (opc == OP_LOAD): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        c[C_M2R]        = 1'b1;
        c[C_MRE]        = 1'b1;
        c[C_BW]         = (f3 != 3'b000);
        dec_o.rd        = rd;
        dec_o.rs1       = rs1;
        dec_o.imm       = imm_i;
      end
      (opc == OP_STORE): begin
        c[C_ALUSRC]     = 1'b1;
        c[C_MWR]        = 1'b1;
        c[C_BW]         = (f3 != 3'b000);
        dec_o.rs1       = rs1;
        dec_o.rs2       = rs2;
        dec_o.imm       = imm_s;
      end
      (opc == OP_LUI): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        dec_o.rd        = rd;
        dec_o.imm       = imm_u;
      end
      (opc == OP_AUIPC): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        c[C_PCA]        = 1'b1;
        dec_o.rd        = rd;
        dec_o.imm       = imm_u;
      end
      (opc == OP_BR): begin
        c[C_BR]         = 1'b1;
        c[C_AOP +: 2]   = AOP_BR;
        dec_o.rs1       = rs1;
        dec_o.rs2       = rs2;
        dec_o.imm       = imm_b;
        dec_o.alu_sel   = ALU_SUB;
      end
      (opc == OP_JAL): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        c[C_JMP]        = 1'b1;
        c[C_PCA]        = 1'b1;
        dec_o.rd        = rd;
        dec_o.imm       = imm_j;
      end
      (opc == OP_JALR): begin
        c[C_RW]         = 1'b1;
        c[C_ALUSRC]     = 1'b1;
        c[C_JMP]        = 1'b1;
        c[C_PCA]        = 1'b1;
        dec_o.rd        = rd;
        dec_o.rs1       = rs1;
        dec_o.imm       = imm_i;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    if (dec_o.rd == 5'd0) c[C_RW] = 1'b0;
    dec_o.ctrls = c;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered multi-lane decode with skid buffer,
// precise illegal masking and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int N_LANES     = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int XLEN        = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  fetch_if.slave  fetch,
  issue_if.master issue
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            vld;
    lane_dec_t       d;
  } slot_t;

  lane_dec_t [N_LANES-1:0] dec;
  slot_t     [N_LANES-1:0] new_s;
  slot_t     [N_LANES-1:0] main_q, main_d;
  slot_t     [N_LANES-1:0] skid_q, skid_d;
  logic                    main_v_q, main_v_d;
  logic                    skid_v_q, skid_v_d;
  logic                    acc, drn;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    decode_lane u_lane (
      .instr_i (fetch.instr[INSTR_WIDTH*i +: 32]),
      .dec_o   (dec[i])
    );
  end

  // first present illegal lane kills every later lane
  always_comb begin
    logic dead;
    dead  = 1'b0;
    new_s = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (fetch.mask[i] && !dead) begin
        new_s[i].pc = fetch.pc + XLEN'(4 * i);
        if (dec[i].illegal) begin
          new_s[i].d.illegal = 1'b1;
          dead = 1'b1;
        end else begin
          new_s[i].d   = dec[i];
          new_s[i].vld = 1'b1;
        end
      end
    end
  end

  assign fetch.ready = ~skid_v_q;
  assign acc = fetch.valid & ~skid_v_q;
  assign drn = main_v_q & issue.ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drn) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = acc;
        if (acc) main_d = new_s;
      end
    end else if (acc) begin
      skid_d   = new_s;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign issue.valid = main_v_q;

  for (genvar i = 0; i < N_LANES; i++) begin : g_out
    assign issue.pc[XLEN*i +: XLEN]  = main_q[i].pc;
    assign issue.lane_vld[i]         = main_q[i].vld;
    assign issue.illegal[i]          = main_q[i].d.illegal;
    assign issue.rd[5*i +: 5]        = main_q[i].d.rd;
    assign issue.rs1[5*i +: 5]       = main_q[i].d.rs1;
    assign issue.rs2[5*i +: 5]       = main_q[i].d.rs2;
    assign issue.imm[XLEN*i +: XLEN] =
      XLEN'($signed(main_q[i].d.imm));
    assign issue.ctrls[CTRL_W*i +: CTRL_W] = main_q[i].d.ctrls;
    assign issue.alu_sel[4*i +: 4]   = main_q[i].d.alu_sel;
  end

endmodule
